// File: rtl/my_associative_buffer_driver.sv
// my_associative_buffer_driver
//
// Requester-side driver for my_associative_buffer. An op arrives over a
// valid/ready handshake and is executed as:
//   IDLE -> LOOKUP (key presented, buffer read sampled)
//        -> COMMIT (buffer ctrl = op code for one cycle)
//        -> RESP   (pre-update hit/data offered until consumed)
// The driver also sequences the buffer's display trigger and blocks ops
// for DISPLAY_BLOCK_CYCLES cycles after each trigger.
//
// Every output is a register. There is no combinational path from op_* or
// resp_ready_i to any output.
//
// Ctrl encoding: NOP=0, CLR=1, LOAD=2, INCR=3. Any other code is issued as NOP.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   op_valid_i / op_ready_o       op request handshake
//   op_code_i, op_key_i,
//   op_data_i                     op code, key, and LOAD data
//   display_req_i                 single-cycle display request
//   resp_valid_o / resp_ready_i   response handshake
//   resp_hit_o, resp_data_o       pre-op hit flag and data (0 on miss)
//   buf_ctrl_o, buf_key_o,
//   buf_data_o                    command bus to the buffer
//   buf_data_output_i,
//   buf_data_valid_i              look-up result from the buffer
//   buf_trigger_display_o         one-cycle display trigger to the buffer
//   hit_count_o, miss_count_o     saturating look-up statistics
//                                 (present only with the macro below)
//
// Optional feature macro: MY_ASSOCIATIVE_BUFFER_DRIVER_STATS_EN
`ifndef MY_ASSOCIATIVE_BUFFER_CTRL_WIDTH
`define MY_ASSOCIATIVE_BUFFER_CTRL_WIDTH 2
`endif

module my_associative_buffer_driver #(
    parameter int unsigned CTRL_WIDTH           = `MY_ASSOCIATIVE_BUFFER_CTRL_WIDTH,
    parameter int unsigned KEY_WIDTH            = 8,
    parameter int unsigned DATA_WIDTH           = 8,
    parameter int unsigned DISPLAY_BLOCK_CYCLES = 450_000_000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  op_valid_i,
    output logic                  op_ready_o,
    input  logic [CTRL_WIDTH-1:0] op_code_i,
    input  logic [KEY_WIDTH-1:0]  op_key_i,
    input  logic [DATA_WIDTH-1:0] op_data_i,
    input  logic                  display_req_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic                  resp_hit_o,
    output logic [DATA_WIDTH-1:0] resp_data_o,
    output logic [CTRL_WIDTH-1:0] buf_ctrl_o,
    output logic [KEY_WIDTH-1:0]  buf_key_o,
    output logic [DATA_WIDTH-1:0] buf_data_o,
    input  logic [DATA_WIDTH-1:0] buf_data_output_i,
    input  logic                  buf_data_valid_i,
    output logic                  buf_trigger_display_o
`ifdef MY_ASSOCIATIVE_BUFFER_DRIVER_STATS_EN
    ,
    output logic [15:0]           hit_count_o,
    output logic [15:0]           miss_count_o
`endif
);

    localparam logic [CTRL_WIDTH-1:0] CtrlNop  = CTRL_WIDTH'(0);
    localparam logic [CTRL_WIDTH-1:0] CtrlClr  = CTRL_WIDTH'(1);
    localparam logic [CTRL_WIDTH-1:0] CtrlLoad = CTRL_WIDTH'(2);
    localparam logic [CTRL_WIDTH-1:0] CtrlIncr = CTRL_WIDTH'(3);

    // Counter only ever holds DISPLAY_BLOCK_CYCLES-1 down to 0.
    localparam int unsigned CntW =
        (DISPLAY_BLOCK_CYCLES > 1) ? $clog2(DISPLAY_BLOCK_CYCLES) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StCommit,
        StResp,
        StDisplay
    } state_e;

    state_e                state_q;
    logic [CTRL_WIDTH-1:0] code_q;
    logic                  pending_q;
    logic [CntW-1:0]       cnt_q;
    logic                  op_ready_q;
    logic                  resp_valid_q;
    logic                  resp_hit_q;
    logic [DATA_WIDTH-1:0] resp_data_q;
    logic [CTRL_WIDTH-1:0] buf_ctrl_q;
    logic [KEY_WIDTH-1:0]  buf_key_q;
    logic [DATA_WIDTH-1:0] buf_data_q;
    logic                  trigger_q;
`ifdef MY_ASSOCIATIVE_BUFFER_DRIVER_STATS_EN
    logic [15:0]           hit_count_q;
    logic [15:0]           miss_count_q;
`endif

    logic code_legal;
    always_comb begin
        code_legal = (code_q == CtrlNop) || (code_q == CtrlClr) ||
                     (code_q == CtrlLoad) || (code_q == CtrlIncr);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            code_q       <= CtrlNop;
            pending_q    <= 1'b0;
            cnt_q        <= '0;
            op_ready_q   <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_data_q  <= '0;
            buf_ctrl_q   <= CtrlNop;
            buf_key_q    <= '0;
            buf_data_q   <= '0;
            trigger_q    <= 1'b0;
`ifdef MY_ASSOCIATIVE_BUFFER_DRIVER_STATS_EN
            hit_count_q  <= '0;
            miss_count_q <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (op_valid_i) begin
                        // Op wins over a simultaneous display request, which is deferred.
                        code_q     <= op_code_i;
                        buf_key_q  <= op_key_i;
                        buf_data_q <= op_data_i;
                        op_ready_q <= 1'b0;
                        state_q    <= StLookup;
                        if (display_req_i) begin
                            pending_q <= 1'b1;
                        end
                    end else if (display_req_i || pending_q) begin
                        trigger_q  <= 1'b1;
                        cnt_q      <= CntW'(DISPLAY_BLOCK_CYCLES - 1);
                        pending_q  <= 1'b0;
                        op_ready_q <= 1'b0;
                        state_q    <= StDisplay;
                    end
                end
                StLookup: begin
                    resp_hit_q  <= buf_data_valid_i;
                    resp_data_q <= buf_data_valid_i ? buf_data_output_i : '0;
                    buf_ctrl_q  <= code_legal ? code_q : CtrlNop;
                    state_q     <= StCommit;
                    if (display_req_i) begin
                        pending_q <= 1'b1;
                    end
`ifdef MY_ASSOCIATIVE_BUFFER_DRIVER_STATS_EN
                    if (buf_data_valid_i) begin
                        if (hit_count_q != 16'hFFFF) begin
                            hit_count_q <= hit_count_q + 16'd1;
                        end
                    end else if (miss_count_q != 16'hFFFF) begin
                        miss_count_q <= miss_count_q + 16'd1;
                    end
`endif
                end
                StCommit: begin
                    buf_ctrl_q   <= CtrlNop;
                    resp_valid_q <= 1'b1;
                    state_q      <= StResp;
                    if (display_req_i) begin
                        pending_q <= 1'b1;
                    end
                end
                StResp: begin
                    if (display_req_i) begin
                        pending_q <= 1'b1;
                    end
                    if (resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        op_ready_q   <= 1'b1;
                        state_q      <= StIdle;
                    end
                end
                StDisplay: begin
                    // Requests arriving here are dropped, not deferred.
                    trigger_q <= 1'b0;
                    if (cnt_q == '0) begin
                        op_ready_q <= 1'b1;
                        state_q    <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: begin
                    buf_ctrl_q   <= CtrlNop;
                    trigger_q    <= 1'b0;
                    resp_valid_q <= 1'b0;
                    op_ready_q   <= 1'b1;
                    state_q      <= StIdle;
                end
            endcase
        end
    end

    assign op_ready_o            = op_ready_q;
    assign resp_valid_o          = resp_valid_q;
    assign resp_hit_o            = resp_hit_q;
    assign resp_data_o           = resp_data_q;
    assign buf_ctrl_o            = buf_ctrl_q;
    assign buf_key_o             = buf_key_q;
    assign buf_data_o            = buf_data_q;
    assign buf_trigger_display_o = trigger_q;
`ifdef MY_ASSOCIATIVE_BUFFER_DRIVER_STATS_EN
    assign hit_count_o           = hit_count_q;
    assign miss_count_o          = miss_count_q;
`endif

endmodule

// File: tb/tb_my_associative_buffer_driver.sv
// Directed testbench for my_associative_buffer_driver with a small behavioural
// associative-buffer model attached to the buffer-side ports.
`ifndef MY_ASSOCIATIVE_BUFFER_CTRL_WIDTH
`define MY_ASSOCIATIVE_BUFFER_CTRL_WIDTH 2
`endif

module tb_my_associative_buffer_driver;

    localparam int unsigned CW    = `MY_ASSOCIATIVE_BUFFER_CTRL_WIDTH;
    localparam int unsigned BLOCK = 20;

    localparam logic [CW-1:0] NOP  = CW'(0);
    localparam logic [CW-1:0] CLR  = CW'(1);
    localparam logic [CW-1:0] LOAD = CW'(2);
    localparam logic [CW-1:0] INCR = CW'(3);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [CW-1:0] op_code = '0;
    logic [7:0]    op_key = '0;
    logic [7:0]    op_data = '0;
    logic          display_req = 1'b0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic          resp_hit;
    logic [7:0]    resp_data;
    logic [CW-1:0] buf_ctrl;
    logic [7:0]    buf_key;
    logic [7:0]    buf_data;
    logic [7:0]    buf_data_output;
    logic          buf_data_valid;
    logic          buf_trigger_display;
`ifdef MY_ASSOCIATIVE_BUFFER_DRIVER_STATS_EN
    logic [15:0]   hit_count;
    logic [15:0]   miss_count;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    my_associative_buffer_driver #(
        .CTRL_WIDTH          (CW),
        .KEY_WIDTH           (8),
        .DATA_WIDTH          (8),
        .DISPLAY_BLOCK_CYCLES(BLOCK)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .op_valid_i           (op_valid),
        .op_ready_o           (op_ready),
        .op_code_i            (op_code),
        .op_key_i             (op_key),
        .op_data_i            (op_data),
        .display_req_i        (display_req),
        .resp_valid_o         (resp_valid),
        .resp_ready_i         (resp_ready),
        .resp_hit_o           (resp_hit),
        .resp_data_o          (resp_data),
        .buf_ctrl_o           (buf_ctrl),
        .buf_key_o            (buf_key),
        .buf_data_o           (buf_data),
        .buf_data_output_i    (buf_data_output),
        .buf_data_valid_i     (buf_data_valid),
        .buf_trigger_display_o(buf_trigger_display)
`ifdef MY_ASSOCIATIVE_BUFFER_DRIVER_STATS_EN
        ,
        .hit_count_o          (hit_count),
        .miss_count_o         (miss_count)
`endif
    );

    // Buffer model: combinational read, update on clock edge from ctrl.
    logic       mdl_clr = 1'b1;
    logic       mem_v [256];
    logic [7:0] mem_d [256];

    assign buf_data_valid  = mem_v[buf_key];
    assign buf_data_output = mem_d[buf_key];

    always @(posedge clk) begin
        if (mdl_clr || buf_ctrl == CLR) begin
            for (int i = 0; i < 256; i++) begin
                mem_v[i] <= 1'b0;
                mem_d[i] <= 8'h00;
            end
        end else if (buf_ctrl == LOAD) begin
            mem_v[buf_key] <= 1'b1;
            mem_d[buf_key] <= buf_data;
        end else if (buf_ctrl == INCR && mem_v[buf_key]) begin
            mem_d[buf_key] <= mem_d[buf_key] + 8'd1;
        end
    end

    // Issue one op and check latency, the ctrl pulse and the response.
    // hold > 0 keeps resp_ready low for that many cycles while in RESP.
    task automatic do_op(input logic [CW-1:0] code, input logic [7:0] key,
                         input logic [7:0] data, input bit disp, input int hold,
                         input bit exp_hit, input logic [7:0] exp_data, input string name);
        int  n;
        int  pulses;
        int  lat;
        bit  got;
        int  exp_pulses;
        n = 0;
        while (op_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        tests_run++;
        if (op_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_ready_wait got=%b want=1", name, op_ready);
            return;
        end
        op_valid    = 1'b1;
        op_code     = code;
        op_key      = key;
        op_data     = data;
        display_req = disp;
        resp_ready  = (hold == 0);
        @(posedge clk); #1;
        op_valid    = 1'b0;
        display_req = 1'b0;
        tests_run++;
        if (op_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_busy op_ready got=%b want=0", name, op_ready);
        end
        pulses = 0;
        lat    = 0;
        got    = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (buf_ctrl !== NOP) pulses++;
            if (resp_valid === 1'b1) got = 1;
        end
        tests_run++;
        if (!got || lat != 2) begin
            tests_failed++;
            $display("FAIL %s_latency got=%0d (seen=%0b) want=2", name, lat, got);
        end
        exp_pulses = (code == NOP) ? 0 : 1;
        tests_run++;
        if (pulses != exp_pulses) begin
            tests_failed++;
            $display("FAIL %s_ctrl_pulses got=%0d want=%0d", name, pulses, exp_pulses);
        end
        tests_run++;
        if (resp_hit !== exp_hit || resp_data !== exp_data) begin
            tests_failed++;
            $display("FAIL %s_resp got hit=%b data=%h want hit=%b data=%h",
                     name, resp_hit, resp_data, exp_hit, exp_data);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (resp_valid !== 1'b1 || resp_data !== exp_data || op_ready !== 1'b0 ||
                buf_ctrl !== NOP) begin
                tests_failed++;
                $display("FAIL %s_hold%0d got valid=%b data=%h ready=%b ctrl=%0d want 1 %h 0 0",
                         name, i, resp_valid, resp_data, op_ready, buf_ctrl, exp_data);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (resp_valid !== 1'b0 || op_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_release got valid=%b ready=%b want 0 1", name, resp_valid, op_ready);
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        mdl_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (op_ready !== 1'b1 || resp_valid !== 1'b0 || buf_trigger_display !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_handshake got ready=%b valid=%b trig=%b want 1 0 0",
                     op_ready, resp_valid, buf_trigger_display);
        end
        tests_run++;
        if (resp_hit !== 1'b0 || resp_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_resp got hit=%b data=%h want 0 00", resp_hit, resp_data);
        end
        tests_run++;
        if (buf_ctrl !== NOP || buf_key !== 8'h00 || buf_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_buf got ctrl=%0d key=%h data=%h want 0 00 00",
                     buf_ctrl, buf_key, buf_data);
        end
        rst     = 1'b0;
        mdl_clr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_load_miss();
        do_op(LOAD, 8'h12, 8'h34, 1'b0, 0, 1'b0, 8'h00, "load_miss");
    endtask

    task automatic test_back_to_back();
        do_op(NOP,  8'h12, 8'h00, 1'b0, 0, 1'b1, 8'h34, "nop_hit");
        do_op(INCR, 8'h12, 8'h00, 1'b0, 0, 1'b1, 8'h34, "incr");
        do_op(NOP,  8'h12, 8'h00, 1'b0, 0, 1'b1, 8'h35, "after_incr");
    endtask

    task automatic test_resp_stall();
        do_op(NOP, 8'h12, 8'h00, 1'b0, 10, 1'b1, 8'h35, "stall");
    endtask

    task automatic test_display();
        int trig;
        int blocked;
        bit first;
        do_op(LOAD, 8'h20, 8'h99, 1'b1, 0, 1'b0, 8'h00, "op_with_disp");
        trig    = 0;
        blocked = 0;
        first   = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (i == 0) first = buf_trigger_display;
            if (buf_trigger_display === 1'b1) trig++;
            if (op_ready === 1'b0) blocked++;
            // A request during the block window must be dropped.
            display_req = (i == 5);
        end
        display_req = 1'b0;
        tests_run++;
        if (first !== 1'b1) begin
            tests_failed++;
            $display("FAIL disp_first_idle got trig=%b want=1", first);
        end
        tests_run++;
        if (trig != 1) begin
            tests_failed++;
            $display("FAIL disp_pulses got=%0d want=1", trig);
        end
        tests_run++;
        if (blocked != BLOCK) begin
            tests_failed++;
            $display("FAIL disp_block got=%0d want=%0d", blocked, BLOCK);
        end
    endtask

    task automatic test_reset_mid_op();
        op_valid = 1'b1;
        op_code  = LOAD;
        op_key   = 8'h56;
        op_data  = 8'h77;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (buf_ctrl !== LOAD) begin
            tests_failed++;
            $display("FAIL rst_pre_commit got ctrl=%0d want=%0d", buf_ctrl, LOAD);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (buf_ctrl !== NOP || op_ready !== 1'b1 || resp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_op got ctrl=%0d ready=%b valid=%b want 0 1 0",
                     buf_ctrl, op_ready, resp_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_op(NOP, 8'h56, 8'h00, 1'b0, 0, 1'b0, 8'h00, "after_rst_miss");
    endtask

`ifdef MY_ASSOCIATIVE_BUFFER_DRIVER_STATS_EN
    task automatic test_stats();
        // One miss already counted by the post-reset look-up of key 56.
        do_op(NOP, 8'hA0, 8'h00, 1'b0, 0, 1'b0, 8'h00, "st_miss1");
        do_op(NOP, 8'hA1, 8'h00, 1'b0, 0, 1'b0, 8'h00, "st_miss2");
        do_op(NOP, 8'h12, 8'h00, 1'b0, 0, 1'b1, 8'h35, "st_hit1");
        do_op(NOP, 8'h12, 8'h00, 1'b0, 0, 1'b1, 8'h35, "st_hit2");
        tests_run++;
        if (miss_count !== 16'd3 || hit_count !== 16'd2) begin
            tests_failed++;
            $display("FAIL stats_counts got miss=%0d hit=%0d want 3 2", miss_count, hit_count);
        end
        dut.hit_count_q = 16'hFFFE;
        do_op(NOP, 8'h12, 8'h00, 1'b0, 0, 1'b1, 8'h35, "st_sat1");
        do_op(NOP, 8'h12, 8'h00, 1'b0, 0, 1'b1, 8'h35, "st_sat2");
        tests_run++;
        if (hit_count !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL stats_saturate got=%h want=ffff", hit_count);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog expired tests=%0d failed=%0d", tests_run, tests_failed);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_miss();
        test_back_to_back();
        test_resp_stall();
        test_display();
        test_reset_mid_op();
`ifdef MY_ASSOCIATIVE_BUFFER_DRIVER_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
